// File: rtl/fpu_pkg.sv
// Shared constants for the FP pipeline controller: unit codes, iterative-unit FSM states
// and operand forwarding selects.
package fpu_pkg;

    localparam logic [1:0] FU_ADD  = 2'b00;
    localparam logic [1:0] FU_MUL  = 2'b01;
    localparam logic [1:0] FU_DIV  = 2'b10;
    localparam logic [1:0] FU_SQRT = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } it_state_t;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_WB = 2'd1;
    localparam logic [1:0] FWD_ED = 2'd2;

endpackage

// File: rtl/fpu_tag_stage.sv
// One execute-stage register of the FP pipe: shifts on adv, otherwise holds, with a
// kill of the write flag and an in-place data load used while the pipe is frozen.
module fpu_tag_stage #(
    parameter int RW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          adv,
    input  logic          kill,
    input  logic          d_ld,
    input  logic [DW-1:0] d_in,
    input  logic          in_w,
    input  logic [RW-1:0] in_n,
    input  logic [1:0]    in_c,
    input  logic [DW-1:0] in_data,
    output logic          w,
    output logic [RW-1:0] n,
    output logic [1:0]    c,
    output logic [DW-1:0] data
);

    always_ff @(posedge clk) begin
        if (clr) begin
            w    <= 1'b0;
            n    <= '0;
            c    <= 2'b00;
            data <= '0;
        end else if (adv) begin
            w    <= in_w;
            n    <= in_n;
            c    <= in_c;
            data <= in_data;
        end else begin
            if (kill) w <= 1'b0;
            if (d_ld) data <= d_in;
        end
    end

endmodule

// File: rtl/fpu_pipe_ctl.sv
// FP pipeline controller: DEPTH execute stages plus writeback, RAW stalls, forwarding and
// the div/sqrt freeze. Define FPU_FWD_EN to forward from E[DEPTH] instead of stalling on it.
module fpu_pipe_ctl
    import fpu_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int RW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          ein,
    input  logic          cancel,
    input  logic          iss_v,
    input  logic [2:0]    iss_fc,
    input  logic          iss_wf,
    input  logic [RW-1:0] iss_fd,
    input  logic [RW-1:0] iss_fs,
    input  logic [RW-1:0] iss_ft,
    input  logic          iss_us,
    input  logic          iss_ut,
    input  logic [DW-1:0] res_add,
    input  logic [DW-1:0] res_mul,
    input  logic [DW-1:0] res_it,
    input  logic          it_done,
    output logic          it_start,
    output logic          it_op,
    output logic          it_abort,
    output logic          e,
    output logic          iss_ack,
    output logic          st_ds,
    output logic          st_raw,
    output logic          sub,
    output logic [DW-1:0] ed,
    output logic [DW-1:0] wd,
    output logic [RW-1:0] wn,
    output logic          ww,
    output logic [1:0]    fwd_s,
    output logic [1:0]    fwd_t
);

`ifdef FPU_FWD_EN
    localparam int STALL_TOP = DEPTH - 1;
`else
    localparam int STALL_TOP = DEPTH;
`endif

    it_state_t      state, state_nx;
    logic           start_nx;
    logic           is_iter;
    logic           stall_s, stall_t;
    logic [DEPTH:1] sw, wv, in_w, kill_v, ld_v;
    logic [RW-1:0]  sn   [1:DEPTH];
    logic [RW-1:0]  in_n [1:DEPTH];
    logic [1:0]     sc   [1:DEPTH];
    logic [1:0]     in_c [1:DEPTH];
    logic [DW-1:0]  sd   [1:DEPTH];
    logic [DW-1:0]  in_d [1:DEPTH];

    function automatic logic hit(input logic w, input logic [RW-1:0] n,
                                 input logic [RW-1:0] r, input logic u);
        return w & u & (n == r);
    endfunction

    assign is_iter = (iss_fc[2:1] == FU_DIV) | (iss_fc[2:1] == FU_SQRT);
    assign st_ds   = (state == ST_WAIT);
    assign e       = ein & ~st_ds;
    // A cancelled E1 instruction is invisible to hazards, forwarding and shifting.
    assign wv      = {sw[DEPTH:2], sw[1] & ~cancel};
    assign st_raw  = iss_v & (stall_s | stall_t);
    assign iss_ack = e & iss_v & ~st_raw;

    always_comb begin
        stall_s = 1'b0;
        stall_t = 1'b0;
        for (int k = 1; k <= STALL_TOP; k++) begin
            stall_s = stall_s | hit(wv[k], sn[k], iss_fs, iss_us);
            stall_t = stall_t | hit(wv[k], sn[k], iss_ft, iss_ut);
        end
    end

    // Forwarding: the later assignment has priority, so E[DEPTH] overrides W.
    always_comb begin
        fwd_s = FWD_RF;
        fwd_t = FWD_RF;
        if (iss_v) begin
            if (hit(ww, wn, iss_fs, iss_us)) fwd_s = FWD_WB;
            if (hit(ww, wn, iss_ft, iss_ut)) fwd_t = FWD_WB;
`ifdef FPU_FWD_EN
            if (hit(wv[DEPTH], sn[DEPTH], iss_fs, iss_us)) fwd_s = FWD_ED;
            if (hit(wv[DEPTH], sn[DEPTH], iss_ft, iss_ut)) fwd_t = FWD_ED;
`endif
        end
    end

    always_comb begin
        case (sc[DEPTH])
            FU_ADD:  ed = res_add;
            FU_MUL:  ed = res_mul;
            default: ed = sd[DEPTH];
        endcase
    end

    always_comb begin
        in_w   = '0;
        kill_v = '0;
        ld_v   = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            in_n[k] = '0;
            in_c[k] = 2'b00;
            in_d[k] = '0;
        end
        in_w[1]   = iss_ack & iss_wf;
        in_n[1]   = iss_ack ? iss_fd : '0;
        in_c[1]   = iss_ack ? iss_fc[2:1] : 2'b00;
        kill_v[1] = cancel;
        ld_v[1]   = st_ds & it_done & ~cancel;
        for (int k = 2; k <= DEPTH; k++) begin
            in_w[k] = wv[k-1];
            in_n[k] = sn[k-1];
            in_c[k] = sc[k-1];
            in_d[k] = sd[k-1];
        end
    end

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        fpu_tag_stage #(.RW(RW), .DW(DW)) u_stage (
            .clk     (clk),
            .clr     (clr),
            .adv     (e),
            .kill    (kill_v[k]),
            .d_ld    (ld_v[k]),
            .d_in    (res_it),
            .in_w    (in_w[k]),
            .in_n    (in_n[k]),
            .in_c    (in_c[k]),
            .in_data (in_d[k]),
            .w       (sw[k]),
            .n       (sn[k]),
            .c       (sc[k]),
            .data    (sd[k])
        );
    end

    always_ff @(posedge clk) begin
        if (clr) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Cancel beats a simultaneous it_done; a reset never reports an abort.
    always_comb begin
        state_nx = state;
        start_nx = 1'b0;
        it_abort = 1'b0;
        case (state)
            ST_IDLE: begin
                if (iss_ack & is_iter) begin
                    state_nx = ST_WAIT;
                    start_nx = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cancel) begin
                    state_nx = ST_IDLE;
                    it_abort = ~clr;
                end else if (it_done) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            it_start <= 1'b0;
            it_op    <= 1'b0;
            sub      <= 1'b0;
            wd       <= '0;
            wn       <= '0;
            ww       <= 1'b0;
        end else begin
            it_start <= start_nx;
            it_op    <= start_nx & (iss_fc[2:1] == FU_SQRT);
            if (iss_ack) sub <= iss_fc[0];
            if (e) begin
                wd <= ed;
                wn <= sn[DEPTH];
                ww <= sw[DEPTH];
            end
        end
    end

endmodule

// File: tb/tb_fpu_pipe_ctl.sv
// Self-checking bench for fpu_pipe_ctl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an in-bench model of in-flight instructions.
module tb_fpu_pipe_ctl;

    localparam int DEPTH = 3;
    localparam int RW    = 5;
    localparam int DW    = 32;
`ifdef FPU_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          clr, ein, cancel, iss_v, iss_wf, iss_us, iss_ut, it_done;
    logic [2:0]    iss_fc;
    logic [RW-1:0] iss_fd, iss_fs, iss_ft;
    logic [DW-1:0] res_add, res_mul, res_it;
    logic          it_start, it_op, it_abort, e, iss_ack, st_ds, st_raw, sub, ww;
    logic [DW-1:0] ed, wd;
    logic [RW-1:0] wn;
    logic [1:0]    fwd_s, fwd_t;

    int n_checks = 0;
    int n_fail   = 0;

    fpu_pipe_ctl #(.DEPTH(DEPTH), .RW(RW), .DW(DW)) dut (
        .clk(clk), .clr(clr), .ein(ein), .cancel(cancel), .iss_v(iss_v), .iss_fc(iss_fc),
        .iss_wf(iss_wf), .iss_fd(iss_fd), .iss_fs(iss_fs), .iss_ft(iss_ft), .iss_us(iss_us),
        .iss_ut(iss_ut), .res_add(res_add), .res_mul(res_mul), .res_it(res_it),
        .it_done(it_done), .it_start(it_start), .it_op(it_op), .it_abort(it_abort), .e(e),
        .iss_ack(iss_ack), .st_ds(st_ds), .st_raw(st_raw), .sub(sub), .ed(ed), .wd(wd),
        .wn(wn), .ww(ww), .fwd_s(fwd_s), .fwd_t(fwd_t)
    );

    always #5 clk = ~clk;

    // Model: one slot per execute stage holding the in-flight instruction, plus W and FSM flags.
    typedef struct packed {
        logic          w;
        logic [RW-1:0] n;
        logic [1:0]    c;
        logic [DW-1:0] d;
    } slot_t;

    slot_t         pe [1:DEPTH];
    logic          m_wait, m_start, m_op, m_sub, m_ww;
    logic [RW-1:0] m_wn;
    logic [DW-1:0] m_wd;
    logic          x_e, x_raw, x_ack, x_abort;
    logic [1:0]    x_fs, x_ft;
    logic [DW-1:0] x_ed;

    task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        for (int k = 1; k <= DEPTH; k++) pe[k] = '0;
        m_wait = 0; m_start = 0; m_op = 0; m_sub = 0; m_ww = 0; m_wn = '0; m_wd = '0;
    endtask

    function automatic logic [1:0] fwd_pick(input logic [RW-1:0] r, input logic u);
        if (!(iss_v && u)) return 2'd0;
        if (FWD_ON && pe[DEPTH].w && pe[DEPTH].n == r) return 2'd2;
        if (m_ww && m_wn == r) return 2'd1;
        return 2'd0;
    endfunction

    task automatic model_outputs();
        logic stall, live;
        stall = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            live = pe[k].w && !(k == 1 && cancel);
            if (live && !(FWD_ON && k == DEPTH) &&
                ((iss_us && pe[k].n == iss_fs) || (iss_ut && pe[k].n == iss_ft)))
                stall = 1'b1;
        end
        x_e     = ein && !m_wait;
        x_raw   = iss_v && stall;
        x_ack   = x_e && iss_v && !x_raw;
        x_abort = m_wait && cancel && !clr;
        x_fs    = fwd_pick(iss_fs, iss_us);
        x_ft    = fwd_pick(iss_ft, iss_ut);
        case (pe[DEPTH].c)
            2'b00:   x_ed = res_add;
            2'b01:   x_ed = res_mul;
            default: x_ed = pe[DEPTH].d;
        endcase
    endtask

    task automatic model_step();
        model_outputs();
        if (clr) begin
            reset_model();
            return;
        end
        m_start = !m_wait && x_ack && iss_fc[2];
        m_op    = m_start && iss_fc[1];
        if (x_ack) m_sub = iss_fc[0];
        if (x_e) begin
            m_wd = x_ed; m_wn = pe[DEPTH].n; m_ww = pe[DEPTH].w;
            for (int k = DEPTH; k >= 2; k--) pe[k] = pe[k-1];
            pe[2].w = pe[2].w && !cancel;
            pe[1] = x_ack ? {iss_wf, iss_fd, iss_fc[2:1], {DW{1'b0}}} : '0;
        end else begin
            if (m_wait && it_done && !cancel) pe[1].d = res_it;
            if (cancel) pe[1].w = 1'b0;
        end
        if (m_wait) m_wait = !(cancel || it_done);
        else        m_wait = x_ack && iss_fc[2];
    endtask

    task automatic sample();
        @(negedge clk);
        model_outputs();
        check_output("e", e, x_e);
        check_output("iss_ack", iss_ack, x_ack);
        check_output("st_ds", st_ds, m_wait);
        check_output("st_raw", st_raw, x_raw);
        check_output("sub", sub, m_sub);
        check_output("ed", ed, x_ed);
        check_output("wd", wd, m_wd);
        check_output("wn", wn, m_wn);
        check_output("ww", ww, m_ww);
        check_output("fwd_s", fwd_s, x_fs);
        check_output("fwd_t", fwd_t, x_ft);
        check_output("it_start", it_start, m_start);
        check_output("it_op", it_op, m_op);
        check_output("it_abort", it_abort, x_abort);
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic quiet();
        clr = 0; ein = 1; cancel = 0; iss_v = 0; iss_fc = 3'b000; iss_wf = 1;
        iss_fd = '0; iss_fs = '0; iss_ft = '0; iss_us = 0; iss_ut = 0;
        res_add = '0; res_mul = '0; res_it = '0; it_done = 0;
    endtask

    task automatic issue(input logic [2:0] fc, input int fd, input int fs, input int ft);
        iss_v = 1; iss_fc = fc; iss_wf = 1; iss_us = 1; iss_ut = 1;
        iss_fd = RW'(fd); iss_fs = RW'(fs); iss_ft = RW'(ft);
    endtask

    task automatic apply_stimulus();
        logic [1:0] unit;
        clr     = ($urandom_range(199) == 0);
        ein     = ($urandom_range(9) != 0);
        cancel  = ($urandom_range(19) == 0);
        iss_v   = ($urandom_range(9) < 6);
        unit    = ($urandom_range(7) == 0) ? 2'($urandom_range(3, 2)) : 2'($urandom_range(1));
        iss_fc  = {unit, 1'($urandom_range(1))};
        iss_wf  = ($urandom_range(9) != 0);
        iss_fd  = RW'($urandom_range(7));
        iss_fs  = RW'($urandom_range(7));
        iss_ft  = RW'($urandom_range(7));
        iss_us  = 1'($urandom_range(1));
        iss_ut  = 1'($urandom_range(1));
        res_add = $urandom();
        res_mul = $urandom();
        res_it  = $urandom();
        it_done = m_wait ? ($urandom_range(5) == 0) : ($urandom_range(29) == 0);
    endtask

    initial begin
        int stalls, cnt;
        logic got, seen;

        quiet();
        clr = 1;
        repeat (2) @(posedge clk);
        #1;
        reset_model();
        clr = 0;

        // Reset state.
        sample();
        check_output("reset_ww", ww, 0);
        check_output("reset_wd", wd, 0);
        check_output("reset_e", e, 1);
        check_output("reset_st_ds", st_ds, 0);
        advance();

        // Back-to-back add f1 and mul f4; writes land on consecutive cycles.
        issue(3'b000, 1, 2, 3);
        sample(); check_output("add_ack", iss_ack, 1); advance();
        issue(3'b010, 4, 5, 6);
        sample(); check_output("mul_ack", iss_ack, 1); advance();
        iss_v = 0; res_add = 32'h1111_0001; res_mul = 32'h2222_0001;
        cycle();
        res_add = 32'hA0A0_0003; res_mul = 32'hB0B0_0003;
        cycle();
        res_add = 32'h1234_5678; res_mul = 32'hC0C0_0004;
        sample();
        check_output("add_ww", ww, 1); check_output("add_wn", wn, 1);
        check_output("add_wd", wd, 32'hA0A0_0003);
        advance();
        sample();
        check_output("mul_ww", ww, 1); check_output("mul_wn", wn, 4);
        check_output("mul_wd", wd, 32'hC0C0_0004);
        advance();

        // RAW: f7 <- f1 + f2 behind add f1.
        issue(3'b000, 1, 2, 3);
        cycle();
        issue(3'b000, 7, 1, 2);
        stalls = 0; got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            sample();
            if (iss_ack) begin
                got = 1;
                check_output("raw_fwd_s", fwd_s, FWD_ON ? 2 : 1);
            end else stalls++;
            advance();
        end
        check_output("raw_ack_seen", 32'(got), 1);
        check_output("raw_stalls", 32'(stalls), FWD_ON ? DEPTH - 1 : DEPTH);
        iss_v = 0;

        // div f8 finishing 10 cycles after it_start.
        issue(3'b100, 8, 9, 10);
        iss_ut = 0;
        sample(); check_output("div_ack", iss_ack, 1); advance();
        iss_v = 0; res_it = 32'h3F80_0000; cnt = 0;
        for (int c = 1; c <= 11; c++) begin
            it_done = (c == 11);
            sample();
            if (c == 1) begin
                check_output("div_start", it_start, 1);
                check_output("div_op", it_op, 0);
            end
            if (st_ds) cnt++;
            advance();
        end
        it_done = 0;
        check_output("div_ds_cycles", 32'(cnt), 11);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            sample();
            if (ww && wn == 8) begin
                got = 1;
                check_output("div_wd", wd, 32'h3F80_0000);
            end
            advance();
        end
        check_output("div_write_seen", 32'(got), 1);

        // div f9 cancelled while waiting; a late it_done is ignored.
        issue(3'b100, 9, 20, 21);
        cycle();
        iss_v = 0;
        repeat (3) cycle();
        cancel = 1;
        sample(); check_output("abort_pulse", it_abort, 1); advance();
        cancel = 0; it_done = 1;
        sample(); check_output("abort_ds", st_ds, 0); advance();
        it_done = 0; cnt = 0;
        for (int i = 0; i < 8; i++) begin
            sample();
            if (ww && wn == 9) cnt++;
            advance();
        end
        check_output("abort_no_write", 32'(cnt), 0);

        // ein low for 5 cycles mid-stream; writes resume in order.
        issue(3'b000, 11, 20, 21); cycle();
        issue(3'b010, 12, 20, 21); cycle();
        iss_v = 0; ein = 0;
        for (int i = 0; i < 5; i++) begin
            sample(); check_output("frz_e", e, 0); advance();
        end
        ein = 1; seen = 0; got = 0;
        for (int i = 0; i < 10; i++) begin
            sample();
            if (ww && wn == 11) seen = 1;
            if (ww && wn == 12 && seen) got = 1;
            advance();
        end
        check_output("frz_order", 32'(got), 1);

        // clr during WAIT with three ops in flight; cancel in the same cycle must not abort.
        issue(3'b000, 13, 20, 21); cycle();
        issue(3'b010, 14, 20, 21); cycle();
        issue(3'b100, 15, 20, 21); cycle();
        iss_v = 0;
        sample(); check_output("clr_wait", st_ds, 1); advance();
        clr = 1; cancel = 1;
        sample(); check_output("clr_no_abort", it_abort, 0); advance();
        clr = 0; cancel = 0;
        issue(3'b000, 1, 13, 14); iss_wf = 0;
        sample();
        check_output("clr_ww", ww, 0); check_output("clr_ds", st_ds, 0);
        check_output("clr_fwd_s", fwd_s, 0); check_output("clr_fwd_t", fwd_t, 0);
        advance();
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            sample();
            if (ww) cnt++;
            advance();
        end
        check_output("clr_no_write", 32'(cnt), 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            apply_stimulus();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_pipe_ctl.md
Name: fpu_pipe_ctl

Overview:
- Parametrised successor of the FP pipeline controller for the MIPS32 FPU.
- Tracks in-flight FP instructions through DEPTH execute stages plus a writeback stage, and selects each result from the external add/mul units or from an iterative div/sqrt unit.
- Adds RAW-hazard detection with bubble insertion, a handshake to the iterative unit with a freeze FSM, forwarding selects, and cancellation of the E1 instruction.
- Sits between the ID stage and the FP register file write port.

Parameters:
DEPTH, 3, number of execute stages E1..E[DEPTH], range 2..8
RW, 5, FP register number width
DW, 32, result data width

Ports:
clk  in  1  clock, rising edge
clr  in  1  synchronous active-high reset
ein  in  1  no_cache_stall; 0 freezes the whole pipe
cancel  in  1  kill the instruction currently in E1
iss_v  in  1  FP instruction presented by ID
iss_fc  in  3  fp control: [2:1] unit code (00 add, 01 mul, 10 div, 11 sqrt), [0] sub
iss_wf  in  1  instruction writes the FP register file
iss_fd  in  RW  destination register
iss_fs  in  RW  source s
iss_ft  in  RW  source t
iss_us  in  1  fs is read
iss_ut  in  1  ft is read
res_add  in  DW  adder result, aligned to E[DEPTH]
res_mul  in  DW  multiplier result, aligned to E[DEPTH]
res_it  in  DW  iterative unit result
it_done  in  1  iterative result valid, 1-cycle pulse
it_start  out  1  pulse: div/sqrt accepted
it_op  out  1  0 div, 1 sqrt; valid with it_start
it_abort  out  1  pulse: iterative op cancelled
e  out  1  advance = ein & ~st_ds
iss_ack  out  1  instruction accepted this edge
st_ds  out  1  freeze caused by div/sqrt
st_raw  out  1  RAW hazard stall
sub  out  1  registered fc[0] of E1
ed  out  DW  E[DEPTH] selected result
wd  out  DW  writeback data
wn  out  RW  writeback register
ww  out  1  writeback enable
fwd_s  out  2  source s select: 0 regfile, 1 wd, 2 ed
fwd_t  out  2  source t select, same encoding

Behaviour:
- Reset (clr=1 at a clk edge): all stage valid/w/n/c/data bits, wd, wn, ww and sub go to 0; the FSM goes to IDLE.
- After reset, every output is 0, except e, which follows ein.
- Stage k holds: w, n, c[1:0], data.
- Effective E1 write enable = e1w & ~cancel. Hazard, forwarding and shifting all use this masked value.
- Advance: when e=1, every stage shifts to the next stage and E[DEPTH] goes to W. In W: wd<=ed, wn, and ww<=w.
- When e=0, all registers hold, including W.
- Issue: iss_ack = e & iss_v & ~st_raw.
  - On ack, E1 loads {iss_wf, iss_fd, iss_fc[2:1]} and sub<=iss_fc[0].
  - On e & ~iss_ack, E1 loads a bubble (w=0, c=00).
- st_raw = iss_v & any stage k in 1..DEPTH with w & n==fs & iss_us, or the same test for ft & iss_ut.
  - A match in W never stalls; it sets fwd=1.
  - When both match, the youngest stage wins for stall purposes.
- Latency: an instruction is accepted at edge 0 and sits in E1. After DEPTH further advancing edges it is in W with ww=1.
- ed mux on E[DEPTH].c: 00 res_add, 01 res_mul, 1x E[DEPTH].data.
- Iterative FSM states: IDLE, WAIT.
  - IDLE -> WAIT on iss_ack with fc[2]=1. it_start pulses for one cycle (the cycle of the accept edge's result); it_op=fc[1].
  - In WAIT, st_ds=1.
  - WAIT + it_done: E1.data<=res_it, then -> IDLE. The pipe resumes the following cycle, so the freeze is always at least 1 cycle.
  - WAIT + cancel: E1.w<=0, it_abort pulses, -> IDLE. A simultaneous it_done is ignored.
  - it_done while in IDLE is ignored.
- cancel while e=0 still kills the E1 instruction at the next edge: E1.w is cleared.
- clr during WAIT: goes to IDLE with no it_abort; the external unit is reset by the same clr.

Optional Feature:
- Macro: FPU_FWD_EN.
- Defined: a match against E[DEPTH] does not stall and gives fwd=2 (ed). Priority is E[DEPTH] > W.
- Undefined: a match against E[DEPTH] stalls; fwd takes only the values 0 and 1.

Decomposition:
- Package fpu_pkg holds:
  - unit code constants FU_ADD=2'b00, FU_MUL=2'b01, FU_DIV=2'b10, FU_SQRT=2'b11
  - FSM state constants
  - fwd select constants FWD_RF=0, FWD_WB=1, FWD_ED=2
- Sub-module fpu_tag_stage: one pipeline stage register with advance/bubble/hold/kill controls. It is instantiated DEPTH times via generate.

Test Plan:
- Back-to-back add f1<-f2+f3, mul f4<-f5*f6, DEPTH=3 -> ww=1 with wn=1, then wn=4, on consecutive cycles 3 advances after each ack; wd equals res_add/res_mul sampled at E3.
- add f1 followed by add f7<-f1+f2 -> st_raw=1 and E1 bubbles until f1 reaches W (E3 with FPU_FWD_EN); then fwd_s=1 (or 2), and iss_ack=1.
- div f8: it_done after 10 cycles with res_it=32'h3F800000 -> it_start 1 cycle; st_ds=1 for 11 cycles; wd=32'h3F800000, wn=8.
- div in WAIT + cancel at cycle 4 -> it_abort pulse; st_ds=0 next cycle; ww never asserted for that op; a late it_done is ignored.
- ein=0 for 5 cycles mid-stream -> all stage registers and outputs stable; results resume in order once ein=1.
- clr asserted during WAIT with 3 ops in flight -> next cycle ww=0, st_ds=0, fwd=0; no writes occur.
